phy_link_supervisor: RTL and testbench



---
 rtl/phy_link_supervisor.sv | 103 ++++++++++
 tb/tb_phy_link_supervisor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/phy_link_supervisor.sv
// Supervisory sequencer for the transceiver reset controller: holds PHY reset, waits for
// ready and block lock, then watches every channel and re-resets on sustained loss.
module phy_link_supervisor #(
  parameter int NUM_CH        = 4,
  parameter int RST_CYCLES    = 1024,
  parameter int READY_TIMEOUT = 1000000,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int LOSS_FILTER   = 64,
  parameter int TMR_W         = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] tx_ready,
  input  logic [NUM_CH-1:0] rx_ready,
  input  logic [NUM_CH-1:0] rx_block_lock,
  input  logic [NUM_CH-1:0] rx_hi_ber,
  output logic              phy_reset,
  output logic [NUM_CH-1:0] link_up,
  output logic              all_link_up,
  output logic [1:0]        sup_state,
  output logic [7:0]        retry_cnt
);

  // state      | meaning
  // RESET_HOLD | phy_reset held high for RST_CYCLES
  // WAIT_READY | waiting for every tx_ready/rx_ready
  // WAIT_LOCK  | waiting for block lock without hi-BER
  // LINK_UP    | link qualified, per-channel loss filtering
  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_READY = 2'd1,
    WAIT_LOCK  = 2'd2,
    LINK_UP    = 2'd3
  } state_t;

  localparam int LW = $clog2(LOSS_FILTER + 1);

  state_t            state;
  state_t            state_nxt;
  logic              retry;
  logic [TMR_W-1:0]  timer;
  logic [LW-1:0]     loss_cnt [NUM_CH];
  logic [NUM_CH-1:0] bad;
  logic [NUM_CH-1:0] loss_hit;

  assign bad       = ~rx_block_lock | rx_hi_ber | ~rx_ready | ~tx_ready;
  assign sup_state = state;

  always_comb begin
    loss_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      loss_hit[i] = (loss_cnt[i] == LW'(LOSS_FILTER));
    end
  end

  always_comb begin
    state_nxt = state;
    retry     = 1'b0;
    case (state)
      RESET_HOLD: begin
        if (timer == TMR_W'(RST_CYCLES - 1)) state_nxt = WAIT_READY;
      end
      WAIT_READY: begin
        if (&tx_ready && &rx_ready) state_nxt = WAIT_LOCK;
        else if (timer == TMR_W'(READY_TIMEOUT - 1)) retry = 1'b1;
      end
      WAIT_LOCK: begin
        if (&rx_block_lock && !(|rx_hi_ber) && &rx_ready) state_nxt = LINK_UP;
        else if (!(&rx_ready) || (timer == TMR_W'(LOCK_TIMEOUT - 1))) retry = 1'b1;
      end
      LINK_UP: begin
        // several channels tripping together still count as a single retry
        if (|loss_hit) retry = 1'b1;
      end
      default: state_nxt = RESET_HOLD;
    endcase
    if (retry) state_nxt = RESET_HOLD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RESET_HOLD;
      timer       <= '0;
      phy_reset   <= 1'b1;
      link_up     <= '0;
      all_link_up <= 1'b0;
      retry_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) loss_cnt[i] <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= (state_nxt != state) ? '0 : timer + TMR_W'(1);
      phy_reset   <= (state_nxt == RESET_HOLD);
      all_link_up <= (state_nxt == LINK_UP);
      link_up     <= (state_nxt == LINK_UP) ? ~bad : '0;
      if (retry && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        loss_cnt[i] <= (state == LINK_UP && state_nxt == LINK_UP && bad[i])
                       ? loss_cnt[i] + LW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_phy_link_supervisor.sv
// Directed bench for phy_link_supervisor with short timers (8/32/32, loss filter 4).
module tb_phy_link_supervisor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tx_ready, rx_ready, rx_block_lock, rx_hi_ber;
  logic       phy_reset, all_link_up;
  logic [3:0] link_up;
  logic [1:0] sup_state;
  logic [7:0] retry_cnt;
  int         checks = 0;
  int         errors = 0;
  int         n;

  always #5 clock = ~clock;

  phy_link_supervisor #(
    .NUM_CH(4), .RST_CYCLES(8), .READY_TIMEOUT(32), .LOCK_TIMEOUT(32),
    .LOSS_FILTER(4), .TMR_W(24)
  ) dut (
    .clock(clock), .reset(reset),
    .tx_ready(tx_ready), .rx_ready(rx_ready),
    .rx_block_lock(rx_block_lock), .rx_hi_ber(rx_hi_ber),
    .phy_reset(phy_reset), .link_up(link_up), .all_link_up(all_link_up),
    .sup_state(sup_state), .retry_cnt(retry_cnt)
  );

  task automatic step(input int cnt = 1);
    repeat (cnt) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // packs {state, phy_reset, link_up, all_link_up, retry_cnt}
  task automatic check_outs(input string tag, input logic [1:0] st, input logic pr,
                            input logic [3:0] lu, input logic alu, input logic [7:0] rc);
    check(tag, {16'd0, sup_state, phy_reset, link_up, all_link_up, retry_cnt},
               {16'd0, st, pr, lu, alu, rc});
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int k = 0;
    while (sup_state !== s && k < budget) begin
      step();
      k++;
    end
    check("wait_state", {30'd0, sup_state}, {30'd0, s});
  endtask

  initial begin
    tx_ready = 4'hF; rx_ready = 4'hF; rx_block_lock = 4'hF; rx_hi_ber = 4'h0;
    step(2);
    check_outs("in_reset", 2'd0, 1'b1, 4'h0, 1'b0, 8'd0);

    // bring-up with everything good
    reset = 1'b0;
    n = 0;
    while (phy_reset === 1'b1 && n < 20) begin n++; step(); end
    check("rst_hold_len", n, 8);
    check_outs("wait_ready", 2'd1, 1'b0, 4'h0, 1'b0, 8'd0);
    step();
    check_outs("wait_lock", 2'd2, 1'b0, 4'h0, 1'b0, 8'd0);
    step();
    check_outs("link_up", 2'd3, 1'b0, 4'hF, 1'b1, 8'd0);

    // 3-cycle lock glitch: filtered
    rx_block_lock[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs("glitch3", 2'd3, 1'b0, 4'hD, 1'b1, 8'd0);
    end
    rx_block_lock = 4'hF;
    step();
    check_outs("glitch3_rec", 2'd3, 1'b0, 4'hF, 1'b1, 8'd0);

    // 4-cycle lock loss: retry
    rx_block_lock[1] = 1'b0;
    step(4);
    check_outs("glitch4", 2'd3, 1'b0, 4'hD, 1'b1, 8'd0);
    rx_block_lock = 4'hF;
    step();
    check_outs("loss_retry", 2'd0, 1'b1, 4'h0, 1'b0, 8'd1);
    wait_state(2'd3, 20);
    check_outs("relink1", 2'd3, 1'b0, 4'hF, 1'b1, 8'd1);

    // two channels hi-BER together: one retry
    rx_hi_ber = 4'b1001;
    step(4);
    check_outs("hiber4", 2'd3, 1'b0, 4'b0110, 1'b1, 8'd1);
    rx_hi_ber = 4'h0;
    step();
    check_outs("hiber_retry", 2'd0, 1'b1, 4'h0, 1'b0, 8'd2);
    wait_state(2'd3, 20);
    check_outs("hiber_once", 2'd3, 1'b0, 4'hF, 1'b1, 8'd2);

    // lose lock everywhere, then let WAIT_LOCK time out
    rx_block_lock = 4'h0;
    step(5);
    check_outs("lock_loss", 2'd0, 1'b1, 4'h0, 1'b0, 8'd3);
    wait_state(2'd2, 20);
    n = 0;
    while (sup_state === 2'd2 && n < 50) begin n++; step(); end
    check("wait_lock_len", n, 32);
    check_outs("lock_timeout", 2'd0, 1'b1, 4'h0, 1'b0, 8'd4);

    // lock arrives on the timeout cycle: lock wins
    wait_state(2'd2, 20);
    step(31);
    check_outs("wl_t31", 2'd2, 1'b0, 4'h0, 1'b0, 8'd4);
    rx_block_lock = 4'hF;
    step();
    check_outs("lock_at_timeout", 2'd3, 1'b0, 4'hF, 1'b1, 8'd4);

    // tx_ready loss counts as bad
    tx_ready[0] = 1'b0;
    step(4);
    check_outs("tx_drop", 2'd3, 1'b0, 4'hE, 1'b1, 8'd4);
    tx_ready = 4'hF;
    step();
    check_outs("tx_retry", 2'd0, 1'b1, 4'h0, 1'b0, 8'd5);
    wait_state(2'd3, 20);

    // single-cycle reset in LINK_UP
    reset = 1'b1;
    step();
    check_outs("mid_reset", 2'd0, 1'b1, 4'h0, 1'b0, 8'd0);
    reset = 1'b0;
    step();
    check_outs("post_reset", 2'd0, 1'b1, 4'h0, 1'b0, 8'd0);

    // rx_ready[2] stuck low: periodic retries, saturating count
    rx_ready[2] = 1'b0;
    wait_state(2'd1, 20);
    n = 0;
    while (sup_state === 2'd1 && n < 50) begin n++; step(); end
    check("wait_ready_len", n, 32);
    check_outs("ready_timeout", 2'd0, 1'b1, 4'h0, 1'b0, 8'd1);
    for (int k = 2; k <= 260; k++) begin
      step(40);
      check_outs("retry_sat", 2'd0, 1'b1, 4'h0, 1'b0, (k > 255) ? 8'd255 : 8'(k));
    end

    // ready completing on the timeout cycle wins
    step(8 + 31);
    check_outs("wr_t31", 2'd1, 1'b0, 4'h0, 1'b0, 8'd255);
    rx_ready = 4'hF;
    step();
    check_outs("ready_at_timeout", 2'd2, 1'b0, 4'h0, 1'b0, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
